// File: rtl/detect_scheduler_if.sv
// detect_scheduler_if
//   Bundles the request and result handshakes of detect_scheduler.
//   master : requester/consumer side (drives req_valid, req_data, res_ready)
//   slave  : scheduler side (drives req_ready, res_valid, res_id, res_count)
//   req_valid [N_REQ]        per-channel request valid
//   req_data  [N_REQ*DATA_W] channel k word at [k*DATA_W +: DATA_W]
//   req_ready [N_REQ]        one-hot, one-cycle accept pulse
//   res_valid / res_ready    result handshake
//   res_id    [ID_W]         channel the result belongs to
//   res_count [CNT_W]        overlapping match count of the word
interface detect_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = $clog2(N_REQ),
    parameter int CNT_W  = $clog2(DATA_W + 1)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    res_valid;
    logic                    res_ready;
    logic [ID_W-1:0]         res_id;
    logic [CNT_W-1:0]        res_count;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_count
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_count
    );
endinterface

// File: rtl/detect_scheduler.sv
// detect_scheduler
//   Round-robin scheduler sharing one serial, overlapping pattern matcher
//   between N_REQ requesters. A granted word is shifted MSB-first, one bit
//   per clock, and its match count is returned tagged with the channel ID.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : request/result handshakes (slave modport)
//   pattern   : match pattern, first-received bit is the MSB
//   match     : one-cycle pulse per match while shifting (registered)
//   busy      : high whenever the scheduler is not IDLE
//   state_out : current state encoding (IDLE=0, SHIFT=1, REPORT=2)
module detect_scheduler #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int ID_W   = $clog2(N_REQ),
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    detect_scheduler_if.slave      bus,
    input  logic [PAT_W-1:0]       pattern,
    output logic                   match,
    output logic                   busy,
    output logic [1:0]             state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [ID_W:0]    N_REQ_W  = (ID_W + 1)'(N_REQ);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PAT_BITS = CNT_W'(PAT_W);

    state_t              state, state_d;
    logic [ID_W-1:0]     ptr;
    logic [DATA_W-1:0]   shreg;
    logic [PAT_W-1:0]    pat_q;
    logic [PAT_W-1:0]    hist;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    count;
    logic [ID_W-1:0]     id_q;
    logic                match_q;

    logic                found;
    logic [ID_W-1:0]     grant;
    logic [ID_W:0]       cand_w;
    logic [ID_W:0]       ptr_w;
    logic [ID_W-1:0]     ptr_next;
    logic [DATA_W-1:0]   word;
    logic [PAT_W-1:0]    hist_next;
    logic [CNT_W-1:0]    bits_seen;
    logic                hit;
    logic [N_REQ-1:0]    req_ready_c;

    // First valid channel at or above ptr, wrapping. ptr < N_REQ, so one
    // conditional subtract is enough to wrap the candidate index.
    always_comb begin
        found  = 1'b0;
        grant  = '0;
        cand_w = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_w = {1'b0, ptr} + (ID_W + 1)'(i);
            if (cand_w >= N_REQ_W)
                cand_w = cand_w - N_REQ_W;
            if (!found && bus.req_valid[cand_w[ID_W-1:0]]) begin
                found = 1'b1;
                grant = cand_w[ID_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_w = {1'b0, grant} + (ID_W + 1)'(1);
        if (ptr_w >= N_REQ_W)
            ptr_w = ptr_w - N_REQ_W;
        ptr_next = ptr_w[ID_W-1:0];
    end

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < N_REQ; k++)
            if (grant == ID_W'(k))
                word = bus.req_data[k*DATA_W +: DATA_W];
    end

    // A match needs a full window of bits from the current word.
    always_comb begin
        hist_next = {hist[PAT_W-2:0], shreg[DATA_W-1]};
        bits_seen = bit_cnt + CNT_W'(1);
        hit       = (state == SHIFT) && (bits_seen >= PAT_BITS) && (hist_next == pat_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (found)              state_d = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_d = REPORT;
            REPORT:  if (bus.res_ready)      state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            shreg   <= '0;
            pat_q   <= '0;
            hist    <= '0;
            bit_cnt <= '0;
            count   <= '0;
            id_q    <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        shreg   <= word;
                        pat_q   <= pattern;
                        id_q    <= grant;
                        ptr     <= ptr_next;
                        hist    <= '0;
                        bit_cnt <= '0;
                        count   <= '0;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[DATA_W-2:0], 1'b0};
                    hist    <= hist_next;
                    bit_cnt <= bits_seen;
                    if (hit) begin
                        match_q <= 1'b1;
                        if (count != '1)
                            count <= count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // req_ready is combinational from IDLE; gate it so it reads 0 during reset.
    always_comb begin
        req_ready_c = '0;
        if ((state == IDLE) && found && !rst)
            req_ready_c = N_REQ'(1) << grant;
    end

    assign bus.req_ready = req_ready_c;
    assign bus.res_valid = (state == REPORT);
    assign bus.res_id    = id_q;
    assign bus.res_count = count;
    assign match         = match_q;
    assign busy          = (state != IDLE);
    assign state_out     = state;

endmodule

// File: doc/detect_scheduler.md
# detect_scheduler

Round-robin scheduler that shares one serial overlapping pattern-match engine between `N_REQ` requester channels. Each channel offers a `DATA_W`-bit word over a valid/ready handshake. The scheduler grants one channel, snapshots the word and the programmed pattern, and shifts the word MSB-first through the internal matcher at one bit per clock. It then returns the overlapping match count for that word, tagged with the channel ID, over a valid/ready result handshake. It sits between the serial detection datapath and the stream sources that need it.

## Interface
- `N_REQ`, default 4: number of requester channels (2..8).
- `DATA_W`, default 8: bits per request word.
- `PAT_W`, default 4: pattern length, 2..`DATA_W`.
- `ID_W`, default 2: equals `$clog2(N_REQ)`.
- `CNT_W`, default 4: equals `$clog2(DATA_W+1)`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `N_REQ`: per-channel request valid.
- `req_data`, in, `N_REQ*DATA_W`: channel k's word is bits [k*DATA_W +: DATA_W].
- `req_ready`, out, `N_REQ`: one-hot, one-cycle accept pulse.
- `pattern`, in, `PAT_W`: match pattern; the first-received bit is the MSB.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: result consumed.
- `res_id`, out, `ID_W`: channel the result belongs to.
- `res_count`, out, `CNT_W`: number of overlapping matches in the word.
- `match`, out, 1: one-cycle pulse on each match during shifting.
- `busy`, out, 1: high in any state other than IDLE.
- `state_out`, out, 2: current state encoding, for debug.

## Operation
- States and encodings: IDLE = 0, SHIFT = 1, REPORT = 2. Encoding 3 is illegal and recovers to IDLE on the next clock.
- IDLE:
  - If any `req_valid` bit is set, grant the first valid channel, searching upward from `ptr` with wrap-around.
  - Pulse `req_ready[grant]` in this cycle.
  - Latch `req_data[grant]` into the shift register, `pattern` into the pattern register, and `grant` into `res_id`.
  - Set `ptr` = (grant+1) mod `N_REQ`, clear the history and count registers, and go to SHIFT.
  - If no request is valid, stay in IDLE.
- SHIFT:
  - Each cycle, shift one data bit, MSB first, into a `PAT_W`-bit history register.
  - A match is history == pattern register, with at least `PAT_W` bits received in the current word.
  - On a match, pulse `match` and increment the count.
  - Overlap is allowed: history is not cleared on a match.
  - History never carries across words.
  - After `DATA_W` bits, go to REPORT.
- REPORT:
  - Hold `res_valid` = 1 with `res_id` and `res_count` stable until `res_ready` = 1 is sampled.
  - On that clock, drop `res_valid` and go to IDLE.
  - No new grant is made in the REPORT cycle.
- Counting: `res_count` saturates at its maximum value. Saturation is unreachable with legal parameters, since the maximum count is `DATA_W`-`PAT_W`+1.
- Pattern changes: changes to `pattern` after a grant do not affect the job in flight.
- Requester protocol: a requester holds `req_valid` and its data until it sees its `req_ready` pulse. Deasserting earlier is a protocol violation with undefined effect on that channel only.
- Reset values (asynchronous, while `rst` = 1):
  - state = IDLE, `ptr` = 0.
  - `req_ready` = 0, `res_valid` = 0, `res_id` = 0, `res_count` = 0, `match` = 0, `busy` = 0, `state_out` = 0.
  - Any job in flight is dropped without a result.

## Timing
- Accept in cycle T (`req_ready` high).
- Bits are shifted in cycles T+1 through T+`DATA_W`. `match` is registered and asserts in the cycle after the bit that completes the match.
- `res_valid` first asserts in cycle T+`DATA_W`+1; this is 9 cycles after accept for the defaults.
- If `res_ready` is high when `res_valid` rises, the next grant can occur at T+`DATA_W`+2. Peak throughput is one word per `DATA_W`+2 cycles.
- Round-robin guarantees that with all channels permanently requesting, the grant order is 0, 1, 2, 3, 0, … and no channel waits more than `N_REQ`-1 jobs.
- Simultaneous new requests in REPORT are seen at the next IDLE cycle.
- Reset deasserting mid-stream: the first grant goes to the lowest-index valid channel.

## Test plan
- Single job:
  - Stimulus: `pattern` = 4'b1101, channel 0 word = 8'b1101_1011.
  - Required: `req_ready[0]` pulses once, two `match` pulses, `res_valid` 9 cycles after accept with `res_id` = 0, `res_count` = 2.
- Overlap and zero cases:
  - `pattern` = 4'b1111, word = 8'hFF → `res_count` = 5.
  - `pattern` = 4'b1101, word = 8'h00 → `res_count` = 0.
  - `pattern` = 4'b0000, word = 8'h00 → `res_count` = 5.
- Round-robin:
  - Stimulus: all 4 channels valid from reset, `res_ready` tied to 1.
  - Required: grant order 0, 1, 2, 3, 0, with consecutive accepts 10 cycles apart.
- Result backpressure:
  - Stimulus: hold `res_ready` = 0 for 5 cycles after `res_valid` rises.
  - Required: `res_valid`, `res_id`, and `res_count` stay stable, and no `req_ready` pulses while waiting.
- Pattern change mid-job:
  - Stimulus: change `pattern` from 4'b1101 to 4'b0000 during SHIFT.
  - Required: the count reflects 4'b1101 only.
- Reset during SHIFT:
  - Stimulus: assert `rst` in the 4th shift cycle.
  - Required: all outputs are at their reset values immediately (asynchronously), no result is produced, and after release channel 0 is granted first.
